// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the PWM generator
package pwm_pkg;
    localparam int PWM_WIDTH = 10;
endpackage

// File: rtl/pwm_counter.sv
// pwm_counter: free-running wrap counter exposing its next value and a period-start strobe
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] cnt_n,
    output logic             start
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    // next count wraps all-ones -> 0; zero marks the start of a period
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        cnt_n = cnt_d;
        start = cnt_d == '0;
    end
    // resets to all ones so the first edge after release begins a period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '1;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pwm.sv
// pwm: edge-aligned PWM with per-period shadowed duty and registered output
module pwm
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] duty,
    output logic             PWM_sig
);
    logic [WIDTH-1:0] cnt_n;
    logic             start;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;
    logic             pwm_q;
    logic             pwm_d;

    pwm_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt_n (cnt_n),
        .start (start)
    );

    // live duty is taken only at period start; the compare uses the same value
    always_comb begin
        duty_d = start ? duty : duty_q;
        pwm_d  = cnt_n < duty_d;
    end
    // shadow duty and output flop; reset forces the output low at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign PWM_sig = pwm_q;
endmodule

// File: tb/tb_pwm.sv
// tb_pwm: randomized and directed checks of pwm against a period-level reference model
module tb_pwm;
    localparam int P = 1024;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] duty = '0;
    logic       PWM_sig;
    int total = 0;
    int bad = 0;
    int pos = 0;
    int pd = 0;
    int hcnt = 0;
    int last_rise = -1;
    bit per_chk = 0;
    logic prev = 1'b0;
    logic exp_pwm = 1'b0;

    pwm #(.WIDTH(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (duty),
        .PWM_sig (PWM_sig)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic clear_model();
        pos = 0;
        hcnt = 0;
        last_rise = -1;
        prev = 1'b0;
    endtask

    // one clock of the reference: position within the period decides the output
    task automatic step();
        int ph;
        @(posedge clk);
        if (rst_n) begin
            ph = pos % P;
            if (ph == 0) begin
                if (pos > 0) check("hicnt", hcnt, pd);
                pd = duty;
                hcnt = 0;
            end
            exp_pwm = ph < pd;
            pos++;
        end else begin
            exp_pwm = 1'b0;
            clear_model();
        end
        #1 check("pwm", PWM_sig, exp_pwm);
        if (PWM_sig === 1'b1) hcnt++;
        if (PWM_sig === 1'b1 && prev === 1'b0) begin
            if (per_chk && last_rise >= 0) check("period", pos - last_rise, P);
            last_rise = pos;
        end
        prev = PWM_sig;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic restart(input int d);
        rst_n = 1'b0;
        duty = 10'(d);
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        run(3);
        check("rst_out", PWM_sig, 0);
        per_chk = 1;
        restart(512);
        run(2 * P + 1);
        per_chk = 0;
        restart(0);
        run(3 * P + 1);
        restart(1023);
        run(2 * P + 1);
        restart(1);
        run(2 * P + 1);
        restart(100);
        run(P + 1);
        restart(200);
        run(50);
        duty = 10'd800;
        run(2 * P);
        per_chk = 1;
        restart(700);
        run(300);
        #3 rst_n = 1'b0;
        duty = 10'd300;
        #1 check("rst_async", PWM_sig, 0);
        #1 rst_n = 1'b1;
        clear_model();
        run(2 * P + 1);
        per_chk = 0;
        restart($urandom_range(0, 1023));
        for (int i = 0; i < 40 * P; i++) begin
            if ($urandom_range(0, 299) == 0) duty = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 499) == 0) duty = ($urandom_range(0, 1) != 0) ? 10'd0 : 10'd1023;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
